// File: rtl/alu_exec_unit.sv
// Registered 6-bit ALU with valid/ready in and out, op counter,
// sticky zero indicator and a DONE state after NUM_OPS results drain.
module alu_exec_unit #(
    parameter int WIDTH   = 6,
    parameter int NUM_OPS = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RESULT,
    output logic             FLAG_Z,
    output logic             FLAG_C,
    output logic             FLAG_V,
    output logic             FLAG_N,
    output logic             zero_seen,
    output logic [CNT_W-1:0] op_count,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int MSB = WIDTH - 1;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_n;
    logic             r_zero_seen;
    logic [CNT_W-1:0] r_op_count;

    logic             w_in_ready;
    logic             w_done;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_out_fire && (r_op_count == LP_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: a draining output slot frees the input in the same cycle
    always_comb begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE, S_RUN: begin
                w_in_ready = !reset && (!r_out_valid || out_ready);
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // One extra bit catches carry out of add and borrow out of sub
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (OP)
            2'b00: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            2'b01: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            2'b10: begin
                w_res = A & B;
            end
            2'b11: begin
                w_res = A | B;
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else if (w_in_fire) begin
            r_result <= w_res;
            r_z      <= (w_res == '0);
            r_c      <= w_c;
            r_v      <= w_v;
            r_n      <= w_res[MSB];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count  <= '0;
            r_zero_seen <= 1'b0;
        end else if (w_out_fire) begin
            if (r_op_count != LP_MAX) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (r_z) begin
                r_zero_seen <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign done      = w_done;
    assign out_valid = r_out_valid;
    assign RESULT    = r_result;
    assign FLAG_Z    = r_z;
    assign FLAG_C    = r_c;
    assign FLAG_V    = r_v;
    assign FLAG_N    = r_n;
    assign zero_seen = r_zero_seen;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued on
// input handshakes and compared on output handshakes.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] A;
    logic [5:0] B;
    logic [1:0] OP;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] RESULT;
    logic       FLAG_Z;
    logic       FLAG_C;
    logic       FLAG_V;
    logic       FLAG_N;
    logic       zero_seen;
    logic [7:0] op_count;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] sb[$];
    int         hs_cnt;
    logic       exp_zs;

    logic [5:0] op_a[8];
    logic [5:0] op_b[8];
    logic [1:0] op_op[8];
    int         n_ops;
    logic [31:0] rdy_mask;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULT    (RESULT),
        .FLAG_Z    (FLAG_Z),
        .FLAG_C    (FLAG_C),
        .FLAG_V    (FLAG_V),
        .FLAG_N    (FLAG_N),
        .zero_seen (zero_seen),
        .op_count  (op_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: unsigned/signed integer arithmetic
    function automatic logic [9:0] model(input logic [5:0] a,
                                         input logic [5:0] b,
                                         input logic [1:0] op);
        int ua, ub, sa, sb_, r, sr;
        logic [5:0] res;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = a[5] ? ua - 64 : ua;
        sb_ = b[5] ? ub - 64 : ub;
        c = 1'b0;
        v = 1'b0;
        res = '0;
        case (op)
            2'b00: begin
                r = ua + ub;
                sr = sa + sb_;
                res = r[5:0];
                c = (r > 63);
                v = (sr > 31) || (sr < -32);
            end
            2'b01: begin
                r = ua - ub + 64;
                sr = sa - sb_;
                res = r[5:0];
                c = (ua < ub);
                v = (sr > 31) || (sr < -32);
            end
            2'b10: res = a & b;
            default: res = a | b;
        endcase
        return {res, (res == 6'd0), c, v, res[5]};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        OP = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result_flags",
              {RESULT, FLAG_Z, FLAG_C, FLAG_V, FLAG_N}, 0);
        check("rst_zs_cnt_done", {zero_seen, op_count, done}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        hs_cnt = 0;
        exp_zs = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int exp_cycles);
        int idx = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [9:0] prev = '0;
        logic [9:0] e;
        logic exp_done;
        while ((idx < n_ops || sb.size() > 0) && cyc < 60) begin
            in_valid = (idx < n_ops);
            A = op_a[idx % 8];
            B = op_b[idx % 8];
            OP = op_op[idx % 8];
            out_ready = (cyc < 32) ? rdy_mask[cyc] : 1'b1;
            #1;
            exp_done = (hs_cnt >= 3);
            check({tag, "_out_valid"}, out_valid, sb.size() != 0);
            check({tag, "_in_ready"}, in_ready,
                  !exp_done && (sb.size() == 0 || out_ready));
            check({tag, "_done"}, done, exp_done);
            if (held && out_valid) begin
                check({tag, "_hold"},
                      {RESULT, FLAG_Z, FLAG_C, FLAG_V, FLAG_N}, prev);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check({tag, "_spurious"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_result"},
                          {RESULT, FLAG_Z, FLAG_C, FLAG_V, FLAG_N}, e);
                    check({tag, "_op_count"}, op_count, hs_cnt);
                    check({tag, "_zero_seen"}, zero_seen, exp_zs);
                    exp_zs = exp_zs | e[3];
                    hs_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, OP));
                idx++;
            end
            held = out_valid && !out_ready;
            prev = {RESULT, FLAG_Z, FLAG_C, FLAG_V, FLAG_N};
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_drained"}, (idx == n_ops) && (sb.size() == 0), 1);
        check({tag, "_cycles"}, cyc, exp_cycles);
    endtask

    initial begin
        do_reset();

        // Add and subtract cases including borrow
        op_a[0] = 6'b101010; op_b[0] = 6'b010101; op_op[0] = 2'b00;
        op_a[1] = 6'b111100; op_b[1] = 6'b000011; op_op[1] = 2'b01;
        op_a[2] = 6'b000011; op_b[2] = 6'b000100; op_op[2] = 2'b01;
        n_ops = 3;
        rdy_mask = 32'hFFFF_FFFF;
        run_stream("arith", 4);
        #1;
        check("arith_done", done, 1);
        check("arith_in_ready", in_ready, 0);
        check("arith_count", op_count, 3);
        check("arith_res_last",
              {RESULT, FLAG_C}, {6'b111111, 1'b1});
        @(negedge clk);

        do_reset();
        op_a[0] = 6'b000000; op_b[0] = 6'b000000; op_op[0] = 2'b00;
        op_a[1] = 6'b011111; op_b[1] = 6'b000001; op_op[1] = 2'b00;
        op_a[2] = 6'b100000; op_b[2] = 6'b000001; op_op[2] = 2'b01;
        n_ops = 3;
        rdy_mask = 32'hFFFF_FFFF;
        run_stream("ovf", 4);
        #1;
        check("ovf_zero_seen_sticky", zero_seen, 1);
        check("ovf_last", {RESULT, FLAG_V}, {6'b011111, 1'b1});
        @(negedge clk);

        // Backpressure; the 4th op is accepted on the DONE-entry cycle
        do_reset();
        op_a[0] = 6'b110011; op_b[0] = 6'b101010; op_op[0] = 2'b10;
        op_a[1] = 6'b110000; op_b[1] = 6'b000011; op_op[1] = 2'b11;
        op_a[2] = 6'b000101; op_b[2] = 6'b000011; op_op[2] = 2'b00;
        op_a[3] = 6'b000001; op_b[3] = 6'b000010; op_op[3] = 2'b01;
        n_ops = 4;
        rdy_mask = 32'hFFFF_FFF1;
        run_stream("bp", 8);
        #1;
        check("bp_count_past_done", op_count, 4);
        check("bp_done", done, 1);
        check("bp_zero_seen", zero_seen, 0);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            A = 6'd7;
            B = 6'd1;
            OP = 2'b00;
            #1;
            check("ignore_in_ready", in_ready, 0);
            check("ignore_out_valid", out_valid, 0);
            check("ignore_count", op_count, 4);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reset while a result is waiting on the output
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b0;
        A = 6'd5;
        B = 6'd3;
        OP = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_latency_valid", out_valid, 1);
        check("mid_result", RESULT, 6'd8);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", RESULT, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_idle_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
